// File: rtl/mips_mem_pkg.sv
// Shared types, default memory map and address-window helper for the
// Harvard memory responder that sits beside mips_cpu_harvard.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MEM_LOAD = 2'd0,
        MEM_HOLD = 2'd1,
        MEM_RUN  = 2'd2
    } mem_state_t;

    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;
    localparam int unsigned DMEM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'hBFC0_0000;
    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_1000;
    localparam logic [3:0]  FULL_MASK          = 4'hF;

    // Widened to 34 bits so windows that end at the top of the 4 GiB space
    // compare correctly.
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [33:0] off;
        logic [33:0] lim;
        off = {2'b00, addr} - {2'b00, base};
        lim = {2'b00, words} << 2;
        return (addr >= base) && (off < lim);
    endfunction

endpackage

// File: rtl/mips_harvard_mem_byte_lane_ram.sv
// Word-organised RAM with one byte-lane-masked synchronous write port and
// one asynchronous read port. Contents are never cleared.
module byte_lane_ram #(
    parameter  int unsigned WORDS = 1024,
    localparam int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] widx_i,
    input  logic [3:0]    wmask_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] ridx_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (wmask_i[lane]) begin
                    mem_q[widx_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
                end
            end
        end
    end

    // Read-before-write: a same-cycle write becomes visible after the edge.
    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mips_harvard_mem.sv
// Harvard instruction/data memory responder: image loader, CPU reset
// sequencing, address decode, sticky fault capture and write counter.
module mips_harvard_mem
    import mips_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        load_target,
    input  logic [15:0] load_index,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        cpu_reset,
    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [15:0] write_count
);

    localparam int unsigned IAW = $clog2(IMEM_WORDS);
    localparam int unsigned DAW = $clog2(DMEM_WORDS);

    localparam logic [1:0] S_LOAD = MEM_LOAD;
    localparam logic [1:0] S_HOLD = MEM_HOLD;
    localparam logic [1:0] S_RUN  = MEM_RUN;

    logic [1:0]  state_q, state_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [15:0] wcount_q, wcount_d;

    logic           in_load, run_act, beat_fire;
    logic           i_hit, d_hit;
    logic           i_fault_c, d_fault_c, d_commit;
    logic [IAW-1:0] i_ridx, i_widx;
    logic [DAW-1:0] d_ridx, d_widx;
    logic [31:0]    imem_rdata, dmem_rdata;
    logic           imem_we, dmem_we;
    logic [3:0]     dmem_mask;
    logic [31:0]    dmem_wdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (load_valid && load_last) state_d = S_HOLD;
            S_HOLD:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LOAD;
        endcase
        if (reset) state_d = S_LOAD;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign in_load    = (state_q == S_LOAD);
    assign load_ready = in_load;
    assign cpu_reset  = (state_q != S_RUN);

    // Reset in the same cycle drops the beat or CPU write in flight.
    assign beat_fire = in_load && load_valid && !reset;
    assign run_act   = (state_q == S_RUN) && !reset;

    assign i_hit  = in_window(instr_address, IMEM_BASE, IMEM_WORDS);
    assign d_hit  = in_window(data_address, DMEM_BASE, DMEM_WORDS);
    assign i_ridx = IAW'((instr_address - IMEM_BASE) >> 2);
    assign d_ridx = DAW'((data_address - DMEM_BASE) >> 2);

    assign i_fault_c = run_act && instr_read && !i_hit && (instr_address != '0);
    assign d_fault_c = run_act && (((data_read || data_write) && !d_hit)
                                   || (data_read && data_write));
    assign d_commit  = run_act && data_write && d_hit && !data_read
                       && (byte_enable != '0);

    assign i_widx     = IAW'(load_index);
    assign imem_we    = beat_fire && !load_target;
    assign dmem_we    = (beat_fire && load_target) || d_commit;
    assign d_widx     = beat_fire ? DAW'(load_index) : d_ridx;
    assign dmem_mask  = beat_fire ? FULL_MASK : byte_enable;
    assign dmem_wdata = beat_fire ? load_data : data_writedata;

    byte_lane_ram #(
        .WORDS (IMEM_WORDS)
    ) u_imem (
        .clk     (clk),
        .we_i    (imem_we),
        .widx_i  (i_widx),
        .wmask_i (FULL_MASK),
        .wdata_i (load_data),
        .ridx_i  (i_ridx),
        .rdata_o (imem_rdata)
    );

    byte_lane_ram #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk     (clk),
        .we_i    (dmem_we),
        .widx_i  (d_widx),
        .wmask_i (dmem_mask),
        .wdata_i (dmem_wdata),
        .ridx_i  (d_ridx),
        .rdata_o (dmem_rdata)
    );

    assign instr_readdata = i_hit ? imem_rdata : '0;
    assign data_readdata  = d_hit ? dmem_rdata : '0;

    // Only the first fault is kept; an instruction fault takes priority for
    // the captured address when both sides fault in one cycle.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        wcount_d     = wcount_q;
        if (!fault_q && (i_fault_c || d_fault_c)) begin
            fault_d      = 1'b1;
            fault_addr_d = i_fault_c ? instr_address : data_address;
        end
        if (d_commit && (wcount_q != 16'hFFFF)) begin
            wcount_d = wcount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            wcount_q     <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            wcount_q     <= wcount_d;
        end
    end

    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign write_count = wcount_q;

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: directed scenarios plus random
// CPU traffic compared every cycle against a behavioural memory model.
module tb_mips_harvard_mem;

    localparam int unsigned IW = 1024;
    localparam int unsigned DW = 1024;
    localparam logic [31:0] IB = 32'hBFC0_0000;
    localparam logic [31:0] DB = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_ready, load_target, load_last;
    logic [15:0] load_index;
    logic [31:0] load_data;
    logic        cpu_reset;
    logic [31:0] instr_address, instr_readdata;
    logic        instr_read;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write;
    logic [3:0]  byte_enable;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] write_count;

    always #5 clk = ~clk;

    mips_harvard_mem #(
        .IMEM_WORDS (IW),
        .DMEM_WORDS (DW),
        .IMEM_BASE  (IB),
        .DMEM_BASE  (DB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_target    (load_target),
        .load_index     (load_index),
        .load_data      (load_data),
        .load_last      (load_last),
        .cpu_reset      (cpu_reset),
        .instr_address  (instr_address),
        .instr_read     (instr_read),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .byte_enable    (byte_enable),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .fault          (fault),
        .fault_addr     (fault_addr),
        .write_count    (write_count)
    );

    // Reference model: memory images with per-word known flags, plus the
    // loader/hold/run progress and the fault/counter bookkeeping.
    logic [31:0] imem_m [IW];
    logic [31:0] dmem_m [DW];
    bit          ik [IW];
    bit          dk [DW];
    bit          m_loading;
    int          m_hold;
    bit          m_fault;
    logic [31:0] m_faddr;
    int unsigned m_wc;
    bit          armed = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] w2, d1, d16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit win(input logic [31:0] a, input logic [31:0] base, input int unsigned words);
        if (a < base) return 1'b0;
        return (64'(a) - 64'(base)) < (64'(words) * 64'd4);
    endfunction

    task automatic check_outputs();
        bit          running;
        int unsigned idx;
        running = !m_loading && (m_hold == 0);
        chk("load_ready", 32'(load_ready), 32'(m_loading));
        chk("cpu_reset", 32'(cpu_reset), 32'(!running));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_addr", fault_addr, m_faddr);
        chk("write_count", 32'(write_count), 32'(m_wc));
        if (win(instr_address, IB, IW)) begin
            idx = (instr_address - IB) / 4;
            if (ik[idx]) chk("instr_readdata", instr_readdata, imem_m[idx]);
        end else begin
            chk("instr_readdata_oow", instr_readdata, 32'h0);
        end
        if (win(data_address, DB, DW)) begin
            idx = (data_address - DB) / 4;
            if (dk[idx]) chk("data_readdata", data_readdata, dmem_m[idx]);
        end else begin
            chk("data_readdata_oow", data_readdata, 32'h0);
        end
    endtask

    task automatic model_edge();
        bit          ifault, dfault;
        int unsigned idx;
        if (reset) begin
            m_loading = 1'b1;
            m_hold    = 0;
            m_fault   = 1'b0;
            m_faddr   = 32'h0;
            m_wc      = 0;
            return;
        end
        if (m_loading) begin
            if (load_valid) begin
                if (load_target) begin
                    idx = load_index % DW;
                    dmem_m[idx] = load_data;
                    dk[idx] = 1'b1;
                end else begin
                    idx = load_index % IW;
                    imem_m[idx] = load_data;
                    ik[idx] = 1'b1;
                end
                if (load_last) begin
                    m_loading = 1'b0;
                    m_hold    = 1;
                end
            end
            return;
        end
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        ifault = instr_read && !win(instr_address, IB, IW) && (instr_address != 32'h0);
        dfault = ((data_read || data_write) && !win(data_address, DB, DW))
                 || (data_read && data_write);
        if (!m_fault && (ifault || dfault)) begin
            m_fault = 1'b1;
            m_faddr = ifault ? instr_address : data_address;
        end
        if (data_write && !dfault && (byte_enable != 4'h0)) begin
            idx = (data_address - DB) / 4;
            for (int l = 0; l < 4; l++)
                if (byte_enable[l]) dmem_m[idx][8*l +: 8] = data_writedata[8*l +: 8];
            dk[idx] = dk[idx] || (byte_enable == 4'hF);
            if (m_wc < 65535) m_wc++;
        end
    endtask

    task automatic clock();
        #1;
        if (armed) check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        instr_read     = 1'b0;
        instr_address  = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_address   = DB;
        byte_enable    = 4'h0;
        data_writedata = 32'h0;
    endtask

    // CPU strobes are randomised during loading; they must have no effect.
    task automatic beat(input bit tgt, input int unsigned idx, input logic [31:0] d, input bit last);
        load_valid     = 1'b1;
        load_target    = tgt;
        load_index     = 16'(idx);
        load_data      = d;
        load_last      = last;
        instr_read     = 1'($urandom_range(0, 1));
        instr_address  = $urandom;
        data_read      = 1'($urandom_range(0, 1));
        data_write     = 1'($urandom_range(0, 1));
        data_address   = DB + 32'(4 * $urandom_range(0, 16));
        byte_enable    = 4'($urandom_range(0, 15));
        data_writedata = $urandom;
        clock();
        load_valid = 1'b0;
        load_last  = 1'b0;
        idle_cpu();
    endtask

    initial begin
        reset = 1'b1;
        load_valid = 1'b0; load_target = 1'b0; load_last = 1'b0;
        load_index = 16'h0; load_data = 32'h0;
        idle_cpu();
        clock();
        armed = 1'b1;
        clock();
        chk("rst_load_ready", 32'(load_ready), 32'h1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_write_count", 32'(write_count), 32'h0);
        reset = 1'b0;

        // Partial image, then a reset with no load_last ever seen.
        d1 = $urandom;
        beat(1'b1, 1, d1, 1'b0);
        for (int unsigned i = 2; i < 16; i++) beat(1'b1, i, $urandom, 1'b0);
        for (int unsigned i = 3; i < 8; i++) beat(1'b0, i + ((i == 5) ? IW : 0), $urandom, 1'b0);
        beat(1'b0, 8, $urandom, 1'b0);
        d16 = $urandom;
        beat(1'b1, DW + 16, d16, 1'b0);
        reset = 1'b1;
        beat(1'b1, 17, $urandom, 1'b0);
        reset = 1'b0;
        chk("midload_load_ready", 32'(load_ready), 32'h1);
        chk("midload_cpu_reset", 32'(cpu_reset), 32'h1);

        // Image: 3 instruction words and one data word carrying load_last.
        beat(1'b0, 0, $urandom, 1'b0);
        beat(1'b0, 1, $urandom, 1'b0);
        w2 = $urandom;
        beat(1'b0, 2, w2, 1'b0);
        load_valid = 1'b1; load_target = 1'b1; load_index = 16'h0;
        load_data = $urandom; load_last = 1'b1;
        #1;
        chk("last_beat_cpu_reset", 32'(cpu_reset), 32'h1);
        clock();
        load_valid = 1'b0; load_last = 1'b0;
        chk("hold_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("hold_load_ready", 32'(load_ready), 32'h0);
        clock();
        chk("run_cpu_reset", 32'(cpu_reset), 32'h0);

        instr_read = 1'b1; instr_address = IB + 32'h8;
        data_address = DB + 32'd64;
        #1;
        chk("fetch_word2", instr_readdata, w2);
        chk("reload_keeps_beat2", data_readdata, d16);
        clock();

        // Byte-lane merge.
        idle_cpu();
        data_write = 1'b1; data_address = DB; byte_enable = 4'hF;
        data_writedata = 32'hAABB_CCDD;
        clock();
        byte_enable = 4'b0101; data_writedata = 32'h1122_3344;
        clock();
        idle_cpu();
        data_read = 1'b1; data_address = DB;
        #1;
        chk("lane_merge", data_readdata, 32'hAA22_CC44);
        chk("lane_count", 32'(write_count), 32'h2);
        clock();

        // Write-then-read visibility.
        idle_cpu();
        data_write = 1'b1; data_address = DB + 32'h4; byte_enable = 4'hF;
        data_writedata = 32'h5566_7788;
        #1;
        chk("same_cycle_old", data_readdata, d1);
        clock();
        idle_cpu();
        data_read = 1'b1; data_address = DB + 32'h4;
        #1;
        chk("next_cycle_new", data_readdata, 32'h5566_7788);
        clock();

        // Halt-address fetch is harmless; first real fault is sticky.
        idle_cpu();
        instr_read = 1'b1; instr_address = 32'h0;
        #1;
        chk("fetch_zero_data", instr_readdata, 32'h0);
        clock();
        chk("fetch_zero_nofault", 32'(fault), 32'h0);
        idle_cpu();
        data_read = 1'b1; data_address = 32'h10;
        clock();
        chk("fault_set", 32'(fault), 32'h1);
        chk("fault_addr_first", fault_addr, 32'h10);
        chk("fault_count_same", 32'(write_count), 32'h3);
        idle_cpu();
        data_write = 1'b1; data_address = 32'h20; byte_enable = 4'hF;
        clock();
        chk("fault_addr_sticky", fault_addr, 32'h10);
        chk("fault_write_uncounted", 32'(write_count), 32'h3);

        // Random traffic after the fault is latched.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            instr_read = 1'($urandom_range(0, 1));
            instr_address = (r < 7) ? IB + 32'(4 * $urandom_range(0, 8))
                          : (r == 7) ? 32'h0 : $urandom;
            r = $urandom_range(0, 15);
            data_read  = (r >= 1 && r < 7) || r == 15;
            data_write = (r >= 7);
            data_address = ($urandom_range(0, 7) == 0) ? $urandom
                         : DB + 32'(4 * $urandom_range(0, 16)) + 32'($urandom_range(0, 3));
            byte_enable = 4'($urandom_range(0, 15));
            data_writedata = $urandom;
            clock();
        end

        // Reset during RUN drops the concurrent write.
        idle_cpu();
        data_write = 1'b1; data_address = DB + 32'h8; byte_enable = 4'hF;
        data_writedata = 32'hDEAD_BEEF;
        reset = 1'b1;
        clock();
        reset = 1'b0;
        idle_cpu();
        chk("runrst_load_ready", 32'(load_ready), 32'h1);
        chk("runrst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("runrst_fault", 32'(fault), 32'h0);
        chk("runrst_count", 32'(write_count), 32'h0);
        data_address = DB + 32'h8;
        clock();
        beat(1'b0, 3, $urandom, 1'b1);
        clock();

        // Counter saturation.
        for (int n = 0; n < 65540; n++) begin
            data_write = 1'b1;
            data_address = DB + 32'(4 * $urandom_range(0, 16));
            byte_enable = 4'($urandom_range(1, 15));
            data_writedata = $urandom;
            clock();
        end
        chk("count_saturated", 32'(write_count), 32'h0000_FFFF);
        idle_cpu();
        clock();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
